// File: rtl/fft_spi_streamer.sv
// rtl/fft_spi_streamer.sv - FFT result frame serialiser onto a write-only SPI link
//
// Purpose: snapshots one FFT output frame (2*N words of MSB/2 bits) on start and
// shifts it out MSB first, each word sign-extended to whole bytes, inside a
// single chip-select window. SCLK rate, CPOL/CPHA and inter-byte gap are set by
// parameters.
// Optional feature macro: FFT_SPI_HEADER_EN prepends A5 5A <frame counter>.
//
// Ports:
//   clk       in   system clock
//   rst_l     in   asynchronous active-low reset
//   data_bus  in   FFT output, word i at [(i+1)*W-1 : i*W]
//   start     in   single-cycle frame request (ignored while busy)
//   busy      out  frame in progress
//   done      out  one-cycle pulse after cs_n deasserts
//   sclk      out  SPI clock
//   mosi      out  SPI data, MSB first
//   cs_n      out  SPI chip select, active low
module fft_spi_streamer #(
  parameter int N                 = 32,
  parameter int MSB               = 16,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CPOL              = 0,
  parameter int CPHA              = 0,
  parameter int GAP_CYCLES        = 0
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [N*MSB-1:0]   data_bus,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sclk,
  output logic               mosi,
  output logic               cs_n
);

  localparam int W    = MSB / 2;
  localparam int BPW  = (W + 7) / 8;
  localparam int EW   = BPW * 8;
  localparam int NW   = 2 * N;
  localparam int NPAY = NW * BPW;
`ifdef FFT_SPI_HEADER_EN
  localparam int HDR  = 3;
`else
  localparam int HDR  = 0;
`endif
  localparam int B     = NPAY + HDR;
  localparam int IW    = $clog2(B + 4);
  localparam int DEPTH = 1 << IW;
  localparam int HW    = $clog2(CLKS_PER_HALF_BIT + 1);
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HW-1:0] HALF_FULL = HW'(CLKS_PER_HALF_BIT);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(B - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_GAP, S_CS_HOLD, S_DONE
  } state_t;

  state_t           r_state;
  logic [N*MSB-1:0] r_frame;
  logic [IW-1:0]    r_byte_idx;
  logic [HW-1:0]    r_half;
  logic [GW-1:0]    r_gap;
  logic [4:0]       r_edge;
  logic [7:0]       r_shift;
  logic             r_busy, r_done, r_sclk, r_mosi, r_cs_n;
`ifdef FFT_SPI_HEADER_EN
  logic [7:0]       r_frame_cnt;
`endif

  logic [NW*EW-1:0] w_ext;
  logic [7:0]       w_bytes [DEPTH];
  logic [IW-1:0]    w_next_idx;
  logic [7:0]       w_cur_byte, w_next_byte;
  logic             w_upd;

  // Sign-extend each snapshot word to whole bytes; the generate-if avoids a
  // zero-width replication when W is already a byte multiple.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_ext
      if (EW > W) begin : g_pad
        assign w_ext[gi*EW +: EW] = {{(EW-W){r_frame[gi*W+W-1]}}, r_frame[gi*W +: W]};
      end else begin : g_nopad
        assign w_ext[gi*EW +: EW] = r_frame[gi*W +: W];
      end
    end
  endgenerate

  // Flat byte table in transmit order; sized to a power of two so the byte
  // index addresses it without width adaptation.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) w_bytes[k] = 8'h00;
`ifdef FFT_SPI_HEADER_EN
    w_bytes[0] = 8'hA5;
    w_bytes[1] = 8'h5A;
    w_bytes[2] = r_frame_cnt;
`endif
    for (int k = 0; k < NPAY; k++)
      w_bytes[HDR+k] = w_ext[((k / BPW) * EW + (BPW - 1 - (k % BPW)) * 8) +: 8];
  end

  assign w_next_idx  = r_byte_idx + IW'(1);
  assign w_cur_byte  = w_bytes[r_byte_idx];
  assign w_next_byte = w_bytes[w_next_idx];
  // r_edge counts edges already made in this byte; the edge about to happen is
  // leading when r_edge is even. CPHA=1 shifts on leading, CPHA=0 on trailing.
  assign w_upd = (CPHA != 0) ? ~r_edge[0] : r_edge[0];

  assign busy = r_busy;
  assign done = r_done;
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_byte_idx <= '0;
      r_half     <= '0;
      r_gap      <= '0;
      r_edge     <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'(CPOL);
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
`ifdef FFT_SPI_HEADER_EN
      r_frame_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frame    <= data_bus;
            r_byte_idx <= '0;
            r_half     <= '0;
            r_busy     <= 1'b1;
            r_cs_n     <= 1'b0;
            r_state    <= S_CS_SETUP;
          end
        end
        S_CS_SETUP: begin
          // Byte 0 is taken from the snapshot, which is valid from this state on.
          if (CPHA == 0) begin
            r_mosi  <= w_cur_byte[7];
            r_shift <= {w_cur_byte[6:0], 1'b0};
          end else begin
            r_shift <= w_cur_byte;
          end
          r_edge <= '0;
          if (r_half == HALF_LAST) begin
            r_half  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_half <= r_half + HW'(1);
          end
        end
        S_SHIFT: begin
          if (r_half == HALF_LAST) begin
            r_half <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 5'd1;
            if (r_edge == 5'd15) begin
              if (r_byte_idx == LAST_IDX) begin
                r_state <= S_CS_HOLD;
              end else begin
                r_byte_idx <= w_next_idx;
                r_edge     <= '0;
                if (CPHA == 0) begin
                  r_mosi  <= w_next_byte[7];
                  r_shift <= {w_next_byte[6:0], 1'b0};
                end else begin
                  r_shift <= w_next_byte;
                end
                if (GAP_CYCLES > 0) begin
                  r_gap   <= '0;
                  r_state <= S_GAP;
                end
              end
            end else if (w_upd) begin
              r_mosi  <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end else begin
            r_half <= r_half + HW'(1);
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_half  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_CS_HOLD: begin
          // Half a bit of idle SCLK with CS low, then CS high for one cycle
          // before the done pulse.
          if (r_half == HALF_FULL) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef FFT_SPI_HEADER_EN
            r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
          end else begin
            if (r_half == HALF_LAST) r_cs_n <= 1'b1;
            r_half <= r_half + HW'(1);
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_half     <= '0;
          r_byte_idx <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
